// File: rtl/iddr_capture.sv
// iddr_capture: input DDR capture register.
// Samples D on both edges of C and presents each rise/fall pair as two
// single-data-rate outputs, Q1 (rising sample) and Q2 (falling sample).
// DDR_CLK_EDGE selects how the pair is aligned to the rising edge:
//   OPPOSITE_EDGE       Q1 moves on posedge, Q2 moves on negedge
//   SAME_EDGE           pair {rise N, fall N-1}, both move on posedge
//   SAME_EDGE_PIPELINED pair {rise N, fall N} one cycle later, on posedge
module iddr_capture #(
  parameter string DDR_CLK_EDGE = "OPPOSITE_EDGE",
  parameter logic  INIT_Q1      = 1'b0,
  parameter logic  INIT_Q2      = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic CE,
  input  logic S,
  input  logic D,
  output logic Q1,
  output logic Q2
);

  localparam int MODE_OPP  = 0;
  localparam int MODE_SAME = 1;
  localparam int MODE_PIPE = 2;
  localparam int MODE_BAD  = 3;

  localparam int MODE =
    (DDR_CLK_EDGE == "OPPOSITE_EDGE")       ? MODE_OPP  :
    (DDR_CLK_EDGE == "SAME_EDGE")           ? MODE_SAME :
    (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED") ? MODE_PIPE : MODE_BAD;

  // An unrecognised alignment mode must stop elaboration.
  generate
    if (MODE == MODE_BAD) begin : g_bad_mode
      $fatal(1, "iddr_capture: illegal DDR_CLK_EDGE value");
    end
  endgenerate

  // Rise path: rise_q, its delayed copy rise_d; fall path retimed: q2_re.
  logic r_rise_q;
  logic r_rise_d;
  logic r_q2_re;
  // Fall path: sample taken on the falling edge.
  logic r_fall_q;

  // Posedge registers: async reset to INIT, then set, then enabled load.
  // q2_re belongs to the fall path, so it resets to INIT_Q2.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_rise_q <= INIT_Q1;
      r_rise_d <= INIT_Q1;
      r_q2_re  <= INIT_Q2;
    end else if (S) begin
      r_rise_q <= 1'b1;
      r_rise_d <= 1'b1;
      r_q2_re  <= 1'b1;
    end else if (CE) begin
      r_rise_q <= D;
      r_rise_d <= r_rise_q;
      r_q2_re  <= r_fall_q;
    end
  end

  // Negedge register: captures the falling-edge data bit.
  always_ff @(negedge C or posedge R) begin
    if (R) begin
      r_fall_q <= INIT_Q2;
    end else if (S) begin
      r_fall_q <= 1'b1;
    end else if (CE) begin
      r_fall_q <= D;
    end
  end

  // Output selection by alignment mode; all outputs come straight from flops.
  assign Q1 = (MODE == MODE_PIPE) ? r_rise_d : r_rise_q;
  assign Q2 = (MODE == MODE_OPP)  ? r_fall_q : r_q2_re;

endmodule
